// File: rtl/conv_window_feeder_pkg.sv
// Shared definitions for the convolution window feeder: default geometry,
// output-stage state encoding and the flat-window word index helper.
package conv_window_feeder_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_S          = 5;
    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Word position of window element (r,c) inside the flat window vector.
    function automatic int win_idx(input int r, input int c, input int s);
        return r * s + c;
    endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel-in / window-out handshake bundle between image source, feeder and conv unit.
// The feeder is the master of the window stream; the environment is the slave side.
interface conv_window_feeder_if #(
    parameter int DATA_WIDTH = conv_window_feeder_pkg::DEF_DATA_WIDTH,
    parameter int S          = conv_window_feeder_pkg::DEF_S
);
    logic                        pix_valid;
    logic                        pix_ready;
    logic [DATA_WIDTH-1:0]       pix_data;
    logic                        win_valid;
    logic                        win_ready;
    logic [0:S*S*DATA_WIDTH-1]   win;
    logic                        win_last;

    modport master (
        input  pix_valid, pix_data, win_ready,
        output pix_ready, win_valid, win, win_last
    );

    modport slave (
        output pix_valid, pix_data, win_ready,
        input  pix_ready, win_valid, win, win_last
    );
endinterface

// File: rtl/conv_line_buffer.sv
// (DEPTH) line buffers of IMG_W pixels; each accepted pixel reads one column of
// all lines and pushes the column down one line at the same address.
module conv_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int IMG_W      = 28,
    parameter int AW         = 5
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [AW-1:0]                     addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic [DEPTH-1:0][DATA_WIDTH-1:0]  rdata
);

    // chain[k] is what line k stores on a write: the new pixel for line 0,
    // otherwise the pre-write contents of the line above it.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] chain;

    for (genvar k = 0; k < DEPTH; k++) begin : g_line
        logic [DATA_WIDTH-1:0] line [IMG_W];

        if (k == 0) begin : g_head
            assign chain[k] = wdata;
        end else begin : g_tail
            assign chain[k] = rdata[k-1];
        end

        assign rdata[k] = line[addr];

        always_ff @(posedge clk) begin
            if (we) line[addr] <= chain[k];
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream to SxS sliding-window stream (stride 1, no padding),
// with a one-entry output stage so full-rate streaming has no bubbles.
module conv_window_feeder
    import conv_window_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int S          = DEF_S,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic                  clk,
    input  logic                  rst,
    conv_window_feeder_if.master  bus
);

    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WIN_BITS = S * S * DATA_WIDTH;

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_EMIT = CW'(S - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_EMIT = RW'(S - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          take;
    logic          emit;
    logic          last_pos;

    logic [S-2:0][DATA_WIDTH-1:0]        lb_rd;
    logic [S-1:0][DATA_WIDTH-1:0]        col_vec;
    logic [S-1:0][S-1:0][DATA_WIDTH-1:0] wreg;
    logic [S-1:0][S-1:0][DATA_WIDTH-1:0] wnext;
    logic [0:WIN_BITS-1]                 win_flat;
    logic [0:WIN_BITS-1]                 win_q;
    logic                                win_last_q;

    out_state_e state, state_nx;

    assign bus.win_valid = (state == OUT_FULL);
    assign bus.pix_ready = !bus.win_valid || bus.win_ready;
    assign bus.win       = win_q;
    assign bus.win_last  = win_last_q;

    assign accept   = bus.pix_valid && bus.pix_ready;
    assign take     = bus.win_valid && bus.win_ready;
    assign emit     = accept && (col >= COL_EMIT) && (row >= ROW_EMIT);
    assign last_pos = (col == COL_MAX) && (row == ROW_MAX);

    conv_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (S - 1),
        .IMG_W      (IMG_W),
        .AW         (CW)
    ) u_lb (
        .clk   (clk),
        .we    (accept),
        .addr  (col),
        .wdata (bus.pix_data),
        .rdata (lb_rd)
    );

    // Line 0 holds the row just above, so it lands one row above the new pixel.
    always_comb begin
        col_vec = '0;
        col_vec[S-1] = bus.pix_data;
        for (int r = 0; r < S - 1; r++) col_vec[r] = lb_rd[S-2-r];
    end

    always_comb begin
        wnext = '0;
        for (int r = 0; r < S; r++) begin
            for (int c = 0; c < S - 1; c++) wnext[r][c] = wreg[r][c+1];
            wnext[r][S-1] = col_vec[r];
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++)
                win_flat[win_idx(r, c, S)*DATA_WIDTH +: DATA_WIDTH] = wnext[r][c];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wreg <= '0;
        else if (accept) wreg <= wnext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_q      <= '0;
            win_last_q <= 1'b0;
        end else if (emit) begin
            win_q      <= win_flat;
            win_last_q <= last_pos;
        end else if (take) begin
            win_last_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= OUT_EMPTY;
        else      state <= state_nx;
    end

    // A take and a new emit in the same cycle keeps the stage full.
    always_comb begin
        state_nx = state;
        case (state)
            OUT_EMPTY: if (emit) state_nx = OUT_FULL;
            OUT_FULL: begin
                if (emit)      state_nx = OUT_FULL;
                else if (take) state_nx = OUT_EMPTY;
            end
            default:   state_nx = OUT_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Window feeder bench: directed 5x5 single-window check plus 3x3-on-8x6 frames
// with random gaps/backpressure/data against an image-array reference model.
module tb_conv_window_feeder;

    localparam int DW = 16;
    localparam int SA = 3, WA = 8, HA = 6;
    localparam int SB = 5, WB = 5, HB = 5;
    localparam int NA = SA * SA * DW;
    localparam int NB = SB * SB * DW;
    localparam int NPIX = WA * HA;

    typedef logic [0:NA-1] win_a_t;
    typedef logic [0:NB-1] win_b_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    conv_window_feeder_if #(.DATA_WIDTH(DW), .S(SA)) ifa ();
    conv_window_feeder_if #(.DATA_WIDTH(DW), .S(SB)) ifb ();

    conv_window_feeder #(.DATA_WIDTH(DW), .S(SA), .IMG_W(WA), .IMG_H(HA)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa.master)
    );
    conv_window_feeder #(.DATA_WIDTH(DW), .S(SB), .IMG_W(WB), .IMG_H(HB)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb.master)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_win, n_last;

    // Reference model: the current frame as a 2-D image plus the raster position.
    logic [DW-1:0] img [HA][WA];
    int            m_row, m_col;
    win_a_t        exp_q[$];
    bit            exp_last_q[$];

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_last_q.delete();
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] p);
        win_a_t w;
        img[m_row][m_col] = p;
        if (m_row >= SA - 1 && m_col >= SA - 1) begin
            w = '0;
            for (int r = 0; r < SA; r++)
                for (int c = 0; c < SA; c++)
                    w[(r*SA+c)*DW +: DW] = img[m_row-SA+1+r][m_col-SA+1+c];
            exp_q.push_back(w);
            exp_last_q.push_back(m_row == HA - 1 && m_col == WA - 1);
        end
        if (m_col == WA - 1) begin
            m_col = 0;
            m_row = (m_row == HA - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    // One cycle on DUT A: drive at negedge, check settled outputs, update model.
    task automatic step(input bit pv, input logic [DW-1:0] pd, input bit wr, output bit acc);
        bit full;
        @(negedge clk);
        ifa.pix_valid = pv;
        ifa.pix_data  = pd;
        ifa.win_ready = wr;
        #1;
        full = (exp_q.size() != 0);
        chk("win_valid", ifa.win_valid, full);
        chk("pix_ready", ifa.pix_ready, !full || wr);
        if (ifa.win_valid && wr) begin
            n_win++;
            if (ifa.win_last) n_last++;
        end
        if (full && wr) begin
            chk("win", ifa.win, exp_q[0]);
            chk("win_last", ifa.win_last, exp_last_q[0]);
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
        end
        acc = pv && (!full || wr);
        if (acc) model_accept(pd);
    endtask

    task automatic feed_pixels(input int from, input int to, input int base, input bit rnd,
                               input int gap, input int rdy);
        logic [DW-1:0] p;
        int            tries;
        bit            acc;
        for (int i = from; i < to; i++) begin
            p = rnd ? DW'($urandom) : DW'(base + (i / WA) * 16 + (i % WA));
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 200) begin
                step($urandom_range(0, 99) >= gap, p, $urandom_range(0, 99) < rdy, acc);
                tries++;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $error("FAIL pix_timeout: pixel %0d not accepted within 200 cycles", i);
            end
        end
    endtask

    task automatic drain_and_count(input int exp_win, input int exp_last);
        bit acc;
        repeat (4) step(1'b0, '0, 1'b1, acc);
        chk("idle_valid", ifa.win_valid, 1'b0);
        chk("win_count", n_win, exp_win);
        chk("last_count", n_last, exp_last);
    endtask

    task automatic frame_start();
        n_win  = 0;
        n_last = 0;
    endtask

    initial begin
        win_b_t exp_b;
        bit     acc;

        ifa.pix_valid = 1'b0; ifa.pix_data = '0; ifa.win_ready = 1'b0;
        ifb.pix_valid = 1'b0; ifb.pix_data = '0; ifb.win_ready = 1'b0;
        model_reset();
        frame_start();

        #2;
        chk("rst_a_valid", ifa.win_valid, 1'b0);
        chk("rst_a_last", ifa.win_last, 1'b0);
        chk("rst_a_ready", ifa.pix_ready, 1'b1);
        chk("rst_a_win", ifa.win, '0);
        chk("rst_b_valid", ifb.win_valid, 1'b0);
        chk("rst_b_win", ifb.win, '0);
        @(negedge clk);
        #2 rst = 1'b1;

        // 5x5 window on a 5x5 image: exactly one window, words 1..25 in order.
        for (int i = 1; i <= SB * SB; i++) begin
            @(negedge clk);
            ifb.pix_valid = 1'b1;
            ifb.pix_data  = DW'(i);
            ifb.win_ready = 1'b1;
            #1;
            chk("b_early_valid", ifb.win_valid, 1'b0);
        end
        @(negedge clk);
        ifb.pix_valid = 1'b0;
        #1;
        exp_b = '0;
        for (int k = 0; k < SB * SB; k++) exp_b[k*DW +: DW] = DW'(k + 1);
        chk("b_valid", ifb.win_valid, 1'b1);
        chk("b_win", ifb.win, exp_b);
        chk("b_last", ifb.win_last, 1'b1);
        @(negedge clk);
        #1;
        chk("b_taken", ifb.win_valid, 1'b0);

        // Full-rate frame, pixel = row*16+col.
        frame_start();
        feed_pixels(0, NPIX, 0, 1'b0, 0, 100);
        drain_and_count(24, 1);

        // Backpressure: hold the window for 10 cycles with a pixel waiting.
        frame_start();
        feed_pixels(0, 21, 0, 1'b0, 0, 100);
        repeat (10) begin
            step(1'b1, DW'(16'h0025), 1'b0, acc);
            chk("bp_ready", ifa.pix_ready, 1'b0);
            chk("bp_win", ifa.win, exp_q[0]);
        end
        feed_pixels(21, NPIX, 0, 1'b0, 0, 100);
        drain_and_count(24, 1);

        // Random valid gaps and random ready, patterned then random data.
        frame_start();
        feed_pixels(0, NPIX, 0, 1'b0, 35, 55);
        drain_and_count(24, 1);
        frame_start();
        feed_pixels(0, NPIX, 0, 1'b1, 20, 70);
        drain_and_count(24, 1);

        // Async reset mid-frame while a window is held, between clock edges.
        frame_start();
        feed_pixels(0, 20, 0, 1'b0, 0, 100);
        step(1'b0, '0, 1'b0, acc);
        #1 rst = 1'b0;
        #1;
        chk("arst_valid", ifa.win_valid, 1'b0);
        chk("arst_last", ifa.win_last, 1'b0);
        chk("arst_ready", ifa.pix_ready, 1'b1);
        chk("arst_win", ifa.win, '0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        frame_start();
        feed_pixels(0, NPIX, 0, 1'b0, 25, 65);
        drain_and_count(24, 1);

        // Two back-to-back frames, second offset by 0x100.
        frame_start();
        feed_pixels(0, NPIX, 0, 1'b0, 25, 70);
        feed_pixels(0, NPIX, 16'h100, 1'b0, 25, 70);
        drain_and_count(48, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
